// File: rtl/bus_initiator_if.sv
// Request/response handshake and parallel-bus control signals for bus_initiator.
// The bidirectional data pins stay outside so the tristate net lives at the top level.
interface bus_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_address;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic [15:0] address_bus;
    logic        write_strobe_b;
    logic        read_strobe_b;

    modport master (
        input  req_valid, req_write, req_address, req_wdata,
        output req_ready, resp_valid, resp_rdata,
        output address_bus, write_strobe_b, read_strobe_b
    );

    modport slave (
        output req_valid, req_write, req_address, req_wdata,
        input  req_ready, resp_valid, resp_rdata,
        input  address_bus, write_strobe_b, read_strobe_b
    );
endinterface

// File: rtl/bus_initiator.sv
// Parallel peripheral bus initiator: turns one-shot valid/ready requests into
// setup / strobe / hold cycles on a 16-bit address, 8-bit tristate data bus.
module bus_initiator #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic               clk,
    input  logic               reset,
    bus_initiator_if.master    bus,
    inout  wire  [7:0]         data_bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);

    state_t      r_state, w_state_next;
    logic [7:0]  r_cnt, w_cnt_next;
    logic        w_accept;
    logic        w_write_next;

    logic        r_write;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic        r_wstb_b, r_rstb_b, r_oe, r_ready, r_resp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && r_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SETUP;
                    w_cnt_next   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (r_cnt == 8'h00) begin
                    w_state_next = S_STROBE;
                    w_cnt_next   = STROBE_LD;
                end else begin
                    w_cnt_next = r_cnt - 8'h01;
                end
            end
            S_STROBE: begin
                if (r_cnt == 8'h00) begin
                    w_state_next = S_HOLD;
                    w_cnt_next   = HOLD_LD;
                end else begin
                    w_cnt_next = r_cnt - 8'h01;
                end
            end
            S_HOLD: begin
                if (r_cnt == 8'h00) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 8'h01;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_write_next = w_accept ? bus.req_write : r_write;

    // Bus pins are registered from the next state so they change exactly on state entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready  <= 1'b0;
            r_resp   <= 1'b0;
            r_wstb_b <= 1'b1;
            r_rstb_b <= 1'b1;
            r_oe     <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= 16'h0000;
            r_wdata  <= 8'h00;
            r_rdata  <= 8'h00;
        end else begin
            r_ready  <= (w_state_next == S_IDLE);
            r_resp   <= (r_state == S_HOLD) && (w_state_next == S_IDLE);
            r_wstb_b <= !((w_state_next == S_STROBE) && r_write);
            r_rstb_b <= !((w_state_next == S_STROBE) && !r_write);
            r_oe     <= (w_state_next != S_IDLE) && w_write_next;
            if (w_accept) begin
                r_write <= bus.req_write;
                r_addr  <= bus.req_address;
                r_wdata <= bus.req_wdata;
            end
            // Read data is captured on the edge that ends the final strobe cycle.
            if ((r_state == S_STROBE) && (w_state_next == S_HOLD) && !r_write) begin
                r_rdata <= data_bus;
            end
        end
    end

    assign bus.req_ready      = r_ready;
    assign bus.resp_valid     = r_resp;
    assign bus.resp_rdata     = r_rdata;
    assign bus.address_bus    = r_addr;
    assign bus.write_strobe_b = r_wstb_b;
    assign bus.read_strobe_b  = r_rstb_b;
    assign data_bus           = r_oe ? r_wdata : 8'hzz;
endmodule
